// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// opcode field position and the reserved opcode pattern.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      LD_IDLE  = 3'd0,
      LD_LO    = 3'd1,
      LD_HI    = 3'd2,
      LD_WRITE = 3'd3,
      LD_CSUM  = 3'd4,
      LD_DONE  = 3'd5,
      LD_ERR   = 3'd6
   } loader_state_e;

   localparam int OPC_MSB = 8;
   localparam int OPC_LSB = 4;

   // Unassigned opcode encoding 5'b1111?; the low bit is a don't-care.
   localparam logic [4:0] cILLEGAL      = 5'b11110;
   localparam logic [4:0] cILLEGAL_MASK = 5'b11110;

   function automatic logic isIllegalOpc(input logic [4:0] opc);
      return (opc & cILLEGAL_MASK) == (cILLEGAL & cILLEGAL_MASK);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the loader, bundled as one interface.
// master: the loader (consumes bytes, drives imem writes).
// slave:  the environment (byte source and imem).
interface imem_loader_if #(
   parameter int IW = 9,
   parameter int AW = 8
);
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_wdata;

   modport master (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream. Byte pairs are packed
// into 9-bit words, written sequentially from address 0, and the load is closed by
// an XOR checksum byte. The core is held in reset until a load completes cleanly.
// Optional build macro IMEM_LOADER_OPCHK_EN rejects words carrying the unassigned
// opcode 5'b1111? (load aborts, the word is not written).
//
// state | meaning
// IDLE  | after reset, waiting for start
// LO    | waiting for low byte (word[7:0])
// HI    | waiting for high byte (bit0 -> word[8], bits 7:1 must be zero)
// WRITE | one-cycle imem write of the packed word
// CSUM  | waiting for checksum byte
// DONE  | load good, core released, waiting for start
// ERR   | load aborted, core held, waiting for start
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int IW = 9,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW:0]   len,
   imem_loader_if.master bus,
   output logic          core_hold,
   output logic          done,
   output logic          err,
   output logic [AW:0]   word_count
);

   localparam logic [2:0] sIdle  = LD_IDLE;
   localparam logic [2:0] sLo    = LD_LO;
   localparam logic [2:0] sHi    = LD_HI;
   localparam logic [2:0] sWrite = LD_WRITE;
   localparam logic [2:0] sCsum  = LD_CSUM;
   localparam logic [2:0] sDone  = LD_DONE;
   localparam logic [2:0] sErr   = LD_ERR;

   localparam logic [AW:0] maxLen  = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] countOne = {{AW{1'b0}}, 1'b1};

   logic [2:0]  state;
   logic [2:0]  stateNext;
   logic [AW:0] lenReg;
   logic [AW:0] wordCount;
   logic [AW:0] wordCountNext;
   logic [AW:0] lenClamped;
   logic [7:0]  csum;
   logic [7:0]  wordLo;
   logic        wordHi;
   logic        accept;
   logic        canStart;
   logic        framingBad;
   logic        opcBad;

   assign accept        = bus.in_valid & bus.in_ready;
   assign canStart      = (state == sIdle) || (state == sDone) || (state == sErr);
   assign lenClamped    = (len > maxLen) ? maxLen : len;
   assign wordCountNext = wordCount + countOne;
   assign framingBad    = |bus.in_data[7:1];

`ifdef IMEM_LOADER_OPCHK_EN
   logic [IW-1:0] hiWord;
   assign hiWord = {bus.in_data[0], wordLo};
   assign opcBad = isIllegalOpc(hiWord[OPC_MSB:OPC_LSB]);
`else
   assign opcBad = 1'b0;
`endif

   // Next-state decode; start is only honoured in the three resting states.
   always_comb begin
      stateNext = state;
      case (state)
         sIdle, sDone, sErr: begin
            if (start) stateNext = (lenClamped == '0) ? sCsum : sLo;
         end
         sLo: begin
            if (accept) stateNext = sHi;
         end
         sHi: begin
            if (accept) stateNext = (framingBad || opcBad) ? sErr : sWrite;
         end
         sWrite: begin
            stateNext = (wordCountNext == lenReg) ? sCsum : sLo;
         end
         sCsum: begin
            if (accept) stateNext = (bus.in_data == csum) ? sDone : sErr;
         end
         default: stateNext = sIdle;
      endcase
   end

   // State register; synchronous reset returns to IDLE even mid-load.
   always_ff @(posedge clk) begin
      if (reset) state <= sIdle;
      else       state <= stateNext;
   end

   // Load bookkeeping: length, word counter, byte packer and running checksum.
   always_ff @(posedge clk) begin
      if (reset) begin
         lenReg    <= '0;
         wordCount <= '0;
         csum      <= '0;
         wordLo    <= '0;
         wordHi    <= 1'b0;
      end else begin
         if (canStart && start) begin
            lenReg    <= lenClamped;
            wordCount <= '0;
            csum      <= '0;
         end
         if (state == sLo && accept) begin
            wordLo <= bus.in_data;
            csum   <= csum ^ bus.in_data;
         end
         if (state == sHi && accept) begin
            wordHi <= bus.in_data[0];
            csum   <= csum ^ bus.in_data;
         end
         if (state == sWrite) wordCount <= wordCountNext;
      end
   end

   assign bus.in_ready   = (state == sLo) || (state == sHi) || (state == sCsum);
   assign bus.imem_we    = (state == sWrite);
   assign bus.imem_addr  = wordCount[AW-1:0];
   assign bus.imem_wdata = {wordHi, wordLo};

   assign core_hold  = (state != sDone);
   assign done       = (state == sDone);
   assign err        = (state == sErr);
   assign word_count = wordCount;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed scenarios plus randomized loads checked
// against a byte-stream reference model. Honours IMEM_LOADER_OPCHK_EN.
module tb_imem_loader;

   localparam int IW = 9;
   localparam int AW = 8;

`ifdef IMEM_LOADER_OPCHK_EN
   localparam bit OPCHK = 1'b1;
`else
   localparam bit OPCHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [AW:0] len;
   logic        core_hold;
   logic        done;
   logic        err;
   logic [AW:0] word_count;

   imem_loader_if #(.IW(IW), .AW(AW)) bus ();

   imem_loader #(.IW(IW), .AW(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .len        (len),
      .bus        (bus.master),
      .core_hold  (core_hold),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   int capAddr[$];
   int capData[$];

   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         capAddr.push_back(int'(bus.imem_addr));
         capData.push_back(int'(bus.imem_wdata));
      end
   end

   // Reference model state
   logic [7:0] stream[$];
   int  expData[$];
   int  expConsumed;
   bit  expDone;

   function automatic void runModel(input int lenIn);
      int eff;
      int x;
      eff = (lenIn > 256) ? 256 : lenIn;
      x = 0;
      expData.delete();
      expDone = 1'b0;
      expConsumed = 0;
      for (int w = 0; w < eff; w++) begin
         int lo;
         int hi;
         int word;
         lo = int'(stream[2*w]);
         hi = int'(stream[2*w+1]);
         x = x ^ lo ^ hi;
         expConsumed = 2*w + 2;
         if (hi > 1) return;
         word = hi*256 + lo;
         if (OPCHK && (word >> 5) == 15) return;
         expData.push_back(word);
      end
      expConsumed = 2*eff + 1;
      expDone = (int'(stream[2*eff]) == x);
   endfunction

   task automatic doReset();
      reset = 1'b1;
      start = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulseStart(input int lenIn);
      start = 1'b1;
      len = lenIn[AW:0];
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offers one byte after a gap; returns just after the negedge following acceptance.
   task automatic sendByte(input logic [7:0] b, input int minGap, input int maxGap, inout bit ok);
      int gap;
      int waitCnt;
      gap = int'($urandom_range(maxGap, minGap));
      waitCnt = 0;
      repeat (gap) begin
         bus.in_valid = 1'b0;
         @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data = b;
      while (bus.in_ready !== 1'b1 && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      if (bus.in_ready !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL handshake_timeout: in_ready=%b after %0d cycles, want 1", bus.in_ready, waitCnt);
         ok = 1'b0;
         bus.in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // One full load from the current stream, checked against the model.
   task automatic runLoad(input int lenIn, input int minGap, input int maxGap, input string name);
      bit ok;
      bit bad;
      ok = 1'b1;
      runModel(lenIn);
      capAddr.delete();
      capData.delete();
      pulseStart(lenIn);
      for (int i = 0; i < expConsumed; i++) begin
         sendByte(stream[i], minGap, maxGap, ok);
         if (!ok) break;
      end
      tests++;
      if (capData.size() != expData.size()) begin
         fails++;
         $display("FAIL %s write_count: got %0d want %0d", name, capData.size(), expData.size());
      end
      tests++;
      bad = 1'b0;
      for (int i = 0; i < capData.size() && i < expData.size(); i++) begin
         if (capAddr[i] != i || capData[i] != expData[i]) begin
            $display("FAIL %s write[%0d]: got addr %0d data %03h want addr %0d data %03h",
                     name, i, capAddr[i], capData[i], i, expData[i]);
            bad = 1'b1;
            break;
         end
      end
      if (bad) fails++;
      tests++;
      if (done !== expDone || err !== !expDone || core_hold !== !expDone) begin
         fails++;
         $display("FAIL %s status: got done=%b err=%b hold=%b want done=%b err=%b hold=%b",
                  name, done, err, core_hold, expDone, !expDone, !expDone);
      end
      tests++;
      if (word_count !== expData.size()) begin
         fails++;
         $display("FAIL %s word_count: got %0d want %0d", name, word_count, expData.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      len = '0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      tests++;
      if (core_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL reset_status: got hold=%b done=%b err=%b want 1 0 0", core_hold, done, err);
      end
      tests++;
      if (bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0) begin
         fails++;
         $display("FAIL reset_handshake: got in_ready=%b imem_we=%b want 0 0", bus.in_ready, bus.imem_we);
      end
      tests++;
      if (bus.imem_addr !== '0 || word_count !== '0) begin
         fails++;
         $display("FAIL reset_counters: got addr=%0d word_count=%0d want 0 0", bus.imem_addr, word_count);
      end
   endtask

   task automatic test_basic();
      stream = '{8'h05, 8'h01, 8'hA2, 8'h00, 8'hA6};
      runLoad(2, 0, 0, "basic");
      tests++;
      if (capData.size() != 2) begin
         fails++;
         $display("FAIL basic_words: got %0d writes want 2", capData.size());
      end else if (capData[0] != 'h105 || capData[1] != 'h0A2) begin
         fails++;
         $display("FAIL basic_words: got %03h %03h want 105 0a2", capData[0], capData[1]);
      end
      tests++;
      if (done !== 1'b1 || core_hold !== 1'b0 || word_count !== 9'd2) begin
         fails++;
         $display("FAIL basic_end: got done=%b hold=%b wc=%0d want 1 0 2", done, core_hold, word_count);
      end
   endtask

   task automatic test_bad_csum();
      stream = '{8'h10, 8'h00, 8'h11};
      runLoad(1, 0, 1, "bad_csum");
      tests++;
      if (err !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1) begin
         fails++;
         $display("FAIL bad_csum_status: got err=%b done=%b hold=%b want 1 0 1", err, done, core_hold);
      end
      tests++;
      if (capData.size() != 1 || capData[0] != 'h010) begin
         fails++;
         $display("FAIL bad_csum_word: got %0d writes want 1 write of 010", capData.size());
      end
   endtask

   task automatic test_framing();
      stream = '{8'h34, 8'h02, 8'h00};
      runLoad(1, 0, 0, "framing");
      tests++;
      if (capData.size() != 0 || err !== 1'b1) begin
         fails++;
         $display("FAIL framing: got writes=%0d err=%b want 0 1", capData.size(), err);
      end
      tests++;
      if (bus.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL framing_ready: got in_ready=%b want 0 in error state", bus.in_ready);
      end
   endtask

   task automatic test_start_ignored();
      bit ok;
      ok = 1'b1;
      stream = '{8'h21, 8'h01, 8'h43, 8'h00, 8'h63};
      runModel(2);
      capData.delete();
      capAddr.delete();
      pulseStart(2);
      sendByte(stream[0], 0, 0, ok);
      start = 1'b1;
      len = 9'd7;
      sendByte(stream[1], 0, 0, ok);
      start = 1'b0;
      for (int i = 2; i < 5; i++) sendByte(stream[i], 0, 1, ok);
      tests++;
      if (done !== 1'b1 || word_count !== 9'd2 || capData.size() != 2) begin
         fails++;
         $display("FAIL start_ignored: got done=%b wc=%0d writes=%0d want 1 2 2",
                  done, word_count, capData.size());
      end
   endtask

   task automatic test_midload_reset();
      bit ok;
      ok = 1'b1;
      stream.delete();
      for (int i = 0; i < 3; i++) begin
         stream.push_back(8'($urandom));
         stream.push_back(8'($urandom_range(1, 0)));
      end
      stream.push_back(8'h00);
      runModel(3);
      capData.delete();
      capAddr.delete();
      pulseStart(3);
      for (int i = 0; i < 4; i++) sendByte(stream[i], 1, 1, ok);
      tests++;
      if (bus.imem_we !== 1'b1) begin
         fails++;
         $display("FAIL midload_write_cycle: got imem_we=%b want 1 after second HI byte", bus.imem_we);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if (capData.size() != 2 || expData.size() < 2) begin
         fails++;
         $display("FAIL midload_writes: got %0d writes want 2", capData.size());
      end else if (capData[0] != expData[0] || capData[1] != expData[1] || capAddr[1] != 1) begin
         fails++;
         $display("FAIL midload_writes: got %03h %03h want %03h %03h",
                  capData[0], capData[1], expData[0], expData[1]);
      end
      tests++;
      if (core_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0 || bus.in_ready !== 1'b0 || word_count !== '0) begin
         fails++;
         $display("FAIL midload_idle: got hold=%b done=%b err=%b rdy=%b wc=%0d want 1 0 0 0 0",
                  core_hold, done, err, bus.in_ready, word_count);
      end
   endtask

   task automatic test_zero_len();
      stream = '{8'h00};
      runLoad(0, 0, 2, "zero_len");
      tests++;
      if (capData.size() != 0 || done !== 1'b1 || core_hold !== 1'b0) begin
         fails++;
         $display("FAIL zero_len: got writes=%0d done=%b hold=%b want 0 1 0", capData.size(), done, core_hold);
      end
      pulseStart(3);
      tests++;
      if (done !== 1'b0 || core_hold !== 1'b1 || bus.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL restart: got done=%b hold=%b rdy=%b want 0 1 1", done, core_hold, bus.in_ready);
      end
      doReset();
   endtask

   task automatic test_opcode();
      stream = '{8'hF0, 8'h01, 8'hF1};
      runLoad(1, 0, 0, "opcode");
      tests++;
      if (OPCHK) begin
         if (capData.size() != 0 || err !== 1'b1) begin
            fails++;
            $display("FAIL opcode_check: got writes=%0d err=%b want 0 1", capData.size(), err);
         end
      end else begin
         if (capData.size() != 1 || capData[0] != 'h1F0 || done !== 1'b1) begin
            fails++;
            $display("FAIL opcode_pass: got writes=%0d done=%b want 1 write of 1f0 and done", capData.size(), done);
         end
      end
   endtask

   task automatic test_max_len();
      logic [7:0] x;
      x = 8'h00;
      stream.delete();
      for (int i = 0; i < 256; i++) begin
         logic [7:0] lo;
         logic [7:0] hi;
         lo = 8'($urandom) & 8'h7F;
         hi = 8'($urandom_range(1, 0));
         stream.push_back(lo);
         stream.push_back(hi);
         x = x ^ lo ^ hi;
      end
      stream.push_back(x);
      runLoad(511, 0, 0, "max_len");
      tests++;
      if (capAddr.size() != 256 || capAddr[255] != 255 || word_count !== 9'd256 || done !== 1'b1) begin
         fails++;
         $display("FAIL max_len: got writes=%0d wc=%0d done=%b want 256 writes ending at 255, wc 256, done",
                  capAddr.size(), word_count, done);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 14; n++) begin
         int l;
         logic [7:0] x;
         l = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(6, 1));
         x = 8'h00;
         stream.delete();
         for (int w = 0; w < l; w++) begin
            logic [7:0] lo;
            logic [7:0] hi;
            lo = 8'($urandom);
            hi = ($urandom_range(9, 0) == 0) ? (8'($urandom) | 8'h02) : 8'($urandom_range(1, 0));
            stream.push_back(lo);
            stream.push_back(hi);
            x = x ^ lo ^ hi;
         end
         if ($urandom_range(3, 0) == 0) x = x ^ 8'(1 << $urandom_range(7, 0));
         stream.push_back(x);
         runLoad(l, 0, 2, $sformatf("random%0d", n));
      end
   endtask

   initial begin
      #2000000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_bad_csum();
      test_framing();
      test_start_ignored();
      test_midload_reset();
      test_zero_len();
      test_opcode();
      test_max_len();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
